brightness_plane_scheduler: RTL

- Sequences binary-coded-modulation (BCM) bit planes for one display row.
- Generates the rolling one-hot brightness mask consumed by the per-subpixel brightness masking stage.
- Hands the shift-out engine one plane at a time, pulses the latch, then holds output_enable for a dwell time proportional to the plane's bit weight.
- Sits between the row/frame controller (start, row_done) and the shift/latch/OE pins of the panel driver.

---
 rtl/brightness_plane_scheduler_if.sv | 24 ++
 rtl/brightness_plane_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/brightness_plane_scheduler_if.sv
// Handshake bundle between the row controller, the BCM plane scheduler and the
// panel shift/latch/OE pins.
interface brightness_plane_scheduler_if #(
  parameter int BRIGHTNESS_BITS = 8
);
  logic                       start;
  logic                       shift_done;
  logic [BRIGHTNESS_BITS-1:0] mask;
  logic                       shift_start;
  logic                       latch;
  logic                       output_enable;
  logic                       busy;
  logic                       row_done;

  modport master (
    output start, shift_done,
    input  mask, shift_start, latch, output_enable, busy, row_done
  );

  modport slave (
    input  start, shift_done,
    output mask, shift_start, latch, output_enable, busy, row_done
  );
endinterface

// File: rtl/brightness_plane_scheduler.sv
// BCM bit-plane sequencer for one display row: shift, latch, weighted display
// dwell and blanking per plane, LSB plane first.
module brightness_plane_scheduler #(
  parameter int BRIGHTNESS_BITS = 8,
  parameter int BASE_TICKS      = 4,
  parameter int BLANK_TICKS     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  brightness_plane_scheduler_if.slave  bus
);

  localparam int PLANE_W    = (BRIGHTNESS_BITS > 1) ? $clog2(BRIGHTNESS_BITS) : 1;
  localparam int DWELL_W    = $clog2(BASE_TICKS) + BRIGHTNESS_BITS;
  localparam int BLANK_W    = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam int BLANK_LOAD = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;

  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BRIGHTNESS_BITS - 1);
  localparam logic [DWELL_W-1:0] DWELL_BASE = DWELL_W'(BASE_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY,
    ST_BLANK,
    ST_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [PLANE_W-1:0]         plane_q, plane_d;
  logic [DWELL_W-1:0]         dwell_q, dwell_d;
  logic [BLANK_W-1:0]         blank_q, blank_d;

  logic [BRIGHTNESS_BITS-1:0] mask_q, mask_d;
  logic                       shift_start_q, shift_start_d;
  logic                       latch_q, latch_d;
  logic                       oe_q, oe_d;
  logic                       busy_q, busy_d;
  logic                       row_done_q, row_done_d;

  // Counter holds weight-1 so DISPLAY lasts BASE_TICKS << plane cycles; the
  // counter width covers the MSB plane without wrapping.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [PLANE_W-1:0] plane);
    return (DWELL_BASE << plane) - DWELL_W'(1);
  endfunction

  function automatic logic [BRIGHTNESS_BITS-1:0] plane_mask(input logic [PLANE_W-1:0] plane);
    return BRIGHTNESS_BITS'(1) << plane;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      plane_q       <= '0;
      dwell_q       <= '0;
      blank_q       <= '0;
      mask_q        <= '0;
      shift_start_q <= 1'b0;
      latch_q       <= 1'b0;
      oe_q          <= 1'b0;
      busy_q        <= 1'b0;
      row_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      plane_q       <= plane_d;
      dwell_q       <= dwell_d;
      blank_q       <= blank_d;
      mask_q        <= mask_d;
      shift_start_q <= shift_start_d;
      latch_q       <= latch_d;
      oe_q          <= oe_d;
      busy_q        <= busy_d;
      row_done_q    <= row_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          plane_d = '0;
        end
      end
      ST_SHIFT: begin
        // The shift_start cycle itself cannot complete a shift.
        if (bus.shift_done && !shift_start_q) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_d = ST_DISPLAY;
        dwell_d = dwell_load(plane_q);
      end
      ST_DISPLAY: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else if (BLANK_TICKS > 0) begin
          state_d = ST_BLANK;
          blank_d = BLANK_W'(BLANK_LOAD);
        end else if (plane_q == LAST_PLANE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
          plane_d = plane_q + PLANE_W'(1);
        end
      end
      ST_BLANK: begin
        if (blank_q != '0) begin
          blank_d = blank_q - BLANK_W'(1);
        end else if (plane_q == LAST_PLANE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
          plane_d = plane_q + PLANE_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        plane_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        plane_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin is a flop aligned
  // with the state it describes.
  always_comb begin
    mask_d        = '0;
    shift_start_d = 1'b0;
    latch_d       = 1'b0;
    oe_d          = 1'b0;
    busy_d        = 1'b1;
    row_done_d    = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_SHIFT: begin
        mask_d        = plane_mask(plane_d);
        shift_start_d = (state_q != ST_SHIFT);
      end
      ST_LATCH: begin
        mask_d  = plane_mask(plane_d);
        latch_d = 1'b1;
      end
      ST_DISPLAY: begin
        mask_d = plane_mask(plane_d);
        oe_d   = 1'b1;
      end
      ST_BLANK: begin
        mask_d = plane_mask(plane_d);
      end
      ST_DONE: begin
        row_done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.mask          = mask_q;
  assign bus.shift_start   = shift_start_q;
  assign bus.latch         = latch_q;
  assign bus.output_enable = oe_q;
  assign bus.busy          = busy_q;
  assign bus.row_done      = row_done_q;

  oe_only_in_display_a: assert property (
    @(posedge clk) disable iff (reset) oe_q |-> (state_q == ST_DISPLAY));

  oe_exclusive_a: assert property (
    @(posedge clk) disable iff (reset) oe_q |-> !(latch_q || shift_start_q));

  mask_onehot0_a: assert property (
    @(posedge clk) disable iff (reset) $onehot0(mask_q));

endmodule
